mux_scan_ctrl: RTL and testbench
================================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL, default 3: cycles each channel is held selected before y is sampled; legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: scan request, sampled only in IDLE.
REQ-005 SHALL have port y, input, 1 bit: output of the downstream 4:1 gate mux.
REQ-006 SHALL have port s0, output, 1 bit: mux select MSB.
REQ-007 SHALL have port s1, output, 1 bit: mux select LSB.
REQ-008 SHALL have port busy, output, 1 bit: high while a scan is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking a completed scan.
REQ-010 SHALL have port sample, output, 4 bits: bit k holds the y value captured from channel k.

Function
REQ-011 SHALL encode the channel index as k = {s0,s1}: 00->i0, 01->i1, 10->i2, 11->i3.
REQ-012 SHALL implement the FSM states IDLE, SCAN and DONE.
REQ-013 SHALL, in IDLE with start=1, enter SCAN on the next edge with ch=0 and dwell count=0.
REQ-014 SHALL, in SCAN, drive {s0,s1}=ch and assert busy=1 on every cycle.
REQ-015 SHALL, in SCAN when dwell count==DWELL-1, capture y into shadow[ch], clear the count and increment ch; otherwise increment the count.
REQ-016 SHALL, when ch3 is captured, load sample <= {y, shadow[2:0]} and enter DONE; sample SHALL change only at this edge.
REQ-017 SHALL, in DONE, assert done=1 and busy=0 for exactly one cycle, then return to IDLE.
REQ-018 SHALL meet the latency: start accepted at edge T gives done=1 during the cycle after edge T+4*DWELL, and sample is valid in that same cycle.
REQ-019 SHALL ignore start while in SCAN or DONE; requests are neither queued nor restarted.
REQ-020 SHALL drive {s0,s1}=00, busy=0 and done=0 in IDLE.
REQ-021 SHALL hold the last sample value unchanged through IDLE and through subsequent scans until the next DONE entry.
REQ-022 SHALL leave the settled value of y at the sampling edge as the only value that affects sample; glitches on y during channel changes SHALL have no effect.

Reset
REQ-023 SHALL, on rst_n=0 at any edge including mid-scan, enter IDLE with ch=0, count=0, shadow=0, sample=4'b0000, s0=s1=0, busy=0 and done=0.
REQ-024 SHALL give rst_n priority over start and over every FSM transition.

Configuration
REQ-025 SHALL provide macro MUX_SCAN_CONT_EN: when defined, DONE SHALL go directly to SCAN (ch=0) if start=1 in the DONE cycle, giving back-to-back scans with one done pulse per scan; when undefined, DONE SHALL always return to IDLE.

Structure
REQ-026 SHALL place in shared package mux_scan_pkg the state encodings (IDLE=2'd0, SCAN=2'd1, DONE=2'd2), the channel-count constant NCH=4 and the dwell-count width constant.
REQ-027 SHALL implement the dwell counter as sub-module dwell_timer with inputs clear/enable and output expire, asserted when count==DWELL-1.
REQ-028 SHALL reject DWELL=0 or DWELL>15 at elaboration.

Verification
REQ-029 SHALL cover: DWELL=3, i0..i3=1,0,1,1, start pulse at edge 0 -> selects 00/01/10/11 each held 3 cycles, done during the cycle after edge 12, sample=4'b1101.
REQ-030 SHALL cover: DWELL=1, i0..i3=0,1,1,0 -> done during the cycle after edge 4, sample=4'b0110.
REQ-031 SHALL cover: start re-pulsed during SCAN -> exactly one done pulse, no restart, sample unaffected by the extra pulse.
REQ-032 SHALL cover: rst_n=0 while on ch2 -> next cycle IDLE, sample=0000, s0=s1=0, busy=0, no done pulse.
REQ-033 SHALL cover: i1 toggled during the first two dwell cycles of ch1 but stable at 1 at its sampling edge -> sample[1]=1.
REQ-034 SHALL cover: MUX_SCAN_CONT_EN defined, start held at 1, DWELL=2 -> done pulses every 9 cycles, busy low only in the DONE cycles.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared definitions for the 4:1 mux scan controller: FSM state encoding,
// channel count and the width of the dwell counter.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NCH   = 4;  // channels behind the downstream 4:1 mux
  localparam int CH_W  = 2;  // width of the channel index {s0,s1}
  localparam int CNT_W = 4;  // dwell counter width, enough for DWELL up to 15

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for the scan controller. Counts cycles while enabled and
// flags expire on the last dwell cycle of a channel, then wraps to zero so
// the next channel starts a fresh dwell.
module dwell_timer
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire = (cnt_q == LAST);

  // Next count: clear wins, otherwise advance and wrap on expire.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = expire ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a downstream 4:1 gate mux. On start it walks the
// select lines {s0,s1} through channels 0..3, holds each for DWELL cycles,
// and captures the settled mux output y on the last dwell cycle of each
// channel. The four captured bits are published on sample together with a
// one-cycle done pulse.
// Optional build macro MUX_SCAN_CONT_EN: when defined, a start seen during
// the DONE cycle launches the next scan immediately (back-to-back scans).
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       done,
  output logic [3:0] sample
);

  if (DWELL < 1 || DWELL > 15) begin : g_bad_dwell
    $error("mux_scan_ctrl: DWELL must be in 1..15");
  end

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [NCH-2:0]     shadow_q, shadow_d;
  logic [NCH-1:0]     sample_q, sample_d;
  logic [CH_W-1:0]    sel;
  logic               tmr_clear, tmr_en, expire;

  dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expire (expire)
  );

  // Next-state, capture and output decode for the IDLE/SCAN/DONE sequence.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    shadow_d  = shadow_q;
    sample_d  = sample_q;
    sel       = '0;
    busy      = 1'b0;
    done      = 1'b0;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_clear = 1'b1;
        ch_d      = '0;
        if (start) state_d = SCAN;
      end
      SCAN: begin
        busy   = 1'b1;
        sel    = ch_q;
        tmr_en = 1'b1;
        if (expire) begin
          ch_d = ch_q + 2'd1;
          if (ch_q == LAST_CH) begin
            // Last channel goes straight to sample, no shadow slot needed.
            sample_d = {y, shadow_q};
            state_d  = DONE;
          end else begin
            for (int k = 0; k < NCH - 1; k++) begin
              if (ch_q == k[CH_W-1:0]) shadow_d[k] = y;
            end
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        tmr_clear = 1'b1;
        ch_d      = '0;
`ifdef MUX_SCAN_CONT_EN
        state_d = start ? SCAN : IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, channel, shadow and published sample registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      shadow_q <= '0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      shadow_q <= shadow_d;
      sample_q <= sample_d;
    end
  end

  assign s0     = sel[1];
  assign s1     = sel[0];
  assign sample = sample_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl. Three instances cover DWELL=3, 1 and 2;
// each drives a behavioural 4:1 mux (y = in[{s0,s1}]) from its own inputs.
module tb_mux_scan_ctrl;

  logic       clk;
  logic       rstA, startA, yA, sA0, sA1, busyA, doneA;
  logic       rstB, startB, yB, sB0, sB1, busyB, doneB;
  logic       rstC, startC, yC, sC0, sC1, busyC, doneC;
  logic [3:0] sampA, sampB, sampC;
  logic [3:0] inA, inB, inC;

  int n_vec = 0;
  int n_err = 0;

  assign yA = inA[{sA0, sA1}];
  assign yB = inB[{sB0, sB1}];
  assign yC = inC[{sC0, sC1}];

  mux_scan_ctrl #(.DWELL(3)) dutA (
    .clk(clk), .rst_n(rstA), .start(startA), .y(yA),
    .s0(sA0), .s1(sA1), .busy(busyA), .done(doneA), .sample(sampA)
  );
  mux_scan_ctrl #(.DWELL(1)) dutB (
    .clk(clk), .rst_n(rstB), .start(startB), .y(yB),
    .s0(sB0), .s1(sB1), .busy(busyB), .done(doneB), .sample(sampB)
  );
  mux_scan_ctrl #(.DWELL(2)) dutC (
    .clk(clk), .rst_n(rstC), .start(startC), .y(yC),
    .s0(sC0), .s1(sC1), .busy(busyC), .done(doneC), .sample(sampC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstA = 0; rstB = 0; rstC = 0;
    startA = 0; startB = 0; startC = 0;
    inA = '0; inB = '0; inC = '0;
    tick(); tick();
    n_vec++; if ({sA0, sA1} !== 2'b00) begin n_err++; $display("FAIL reset_sel got=%b exp=00", {sA0, sA1}); end
    n_vec++; if (busyA !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busyA); end
    n_vec++; if (doneA !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", doneA); end
    n_vec++; if (sampA !== 4'b0000) begin n_err++; $display("FAIL reset_sampleA got=%b exp=0000", sampA); end
    n_vec++; if (sampB !== 4'b0000) begin n_err++; $display("FAIL reset_sampleB got=%b exp=0000", sampB); end
    n_vec++; if (sampC !== 4'b0000) begin n_err++; $display("FAIL reset_sampleC got=%b exp=0000", sampC); end
    rstA = 1; rstB = 1; rstC = 1;
    tick();
  endtask

  task automatic test_scan_d3();
    logic [1:0] e;
    inA = 4'b1101;
    startA = 1; tick(); startA = 0;
    for (int n = 0; n < 12; n++) begin
      e = 2'(n / 3);
      n_vec++; if ({sA0, sA1} !== e) begin n_err++; $display("FAIL d3_sel cyc=%0d got=%b exp=%b", n, {sA0, sA1}, e); end
      n_vec++; if (busyA !== 1'b1 || doneA !== 1'b0) begin n_err++; $display("FAIL d3_busy cyc=%0d got busy=%b done=%b exp busy=1 done=0", n, busyA, doneA); end
      n_vec++; if (sampA !== 4'b0000) begin n_err++; $display("FAIL d3_sample_hold cyc=%0d got=%b exp=0000", n, sampA); end
      tick();
    end
    n_vec++; if (doneA !== 1'b1 || busyA !== 1'b0) begin n_err++; $display("FAIL d3_done got done=%b busy=%b exp done=1 busy=0", doneA, busyA); end
    n_vec++; if (sampA !== 4'b1101) begin n_err++; $display("FAIL d3_sample got=%b exp=1101", sampA); end
    n_vec++; if ({sA0, sA1} !== 2'b00) begin n_err++; $display("FAIL d3_done_sel got=%b exp=00", {sA0, sA1}); end
    tick();
    n_vec++; if (doneA !== 1'b0 || busyA !== 1'b0) begin n_err++; $display("FAIL d3_idle got done=%b busy=%b exp 0 0", doneA, busyA); end
    n_vec++; if (sampA !== 4'b1101) begin n_err++; $display("FAIL d3_idle_sample got=%b exp=1101", sampA); end
  endtask

  task automatic test_scan_d1();
    inB = 4'b0110;
    startB = 1; tick(); startB = 0;
    for (int n = 0; n < 4; n++) begin
      n_vec++; if ({sB0, sB1} !== 2'(n) || busyB !== 1'b1 || doneB !== 1'b0) begin
        n_err++; $display("FAIL d1_scan cyc=%0d got sel=%b busy=%b done=%b exp sel=%b busy=1 done=0", n, {sB0, sB1}, busyB, doneB, 2'(n));
      end
      tick();
    end
    n_vec++; if (doneB !== 1'b1 || busyB !== 1'b0) begin n_err++; $display("FAIL d1_done got done=%b busy=%b exp done=1 busy=0", doneB, busyB); end
    n_vec++; if (sampB !== 4'b0110) begin n_err++; $display("FAIL d1_sample got=%b exp=0110", sampB); end
    tick();
    n_vec++; if (doneB !== 1'b0) begin n_err++; $display("FAIL d1_done_width got=%b exp=0", doneB); end
  endtask

  task automatic test_restart();
    int dones = 0;
    inA = 4'b0010;
    startA = 1; tick(); startA = 0;
    for (int n = 0; n < 12; n++) begin
      startA = (n == 5);
      n_vec++; if (busyA !== 1'b1 || sampA !== 4'b1101) begin
        n_err++; $display("FAIL restart_scan cyc=%0d got busy=%b sample=%b exp busy=1 sample=1101", n, busyA, sampA);
      end
      if (doneA === 1'b1) dones++;
      tick();
    end
    startA = 0;
    n_vec++; if (doneA !== 1'b1 || sampA !== 4'b0010) begin
      n_err++; $display("FAIL restart_done got done=%b sample=%b exp done=1 sample=0010", doneA, sampA);
    end
    for (int n = 0; n < 16; n++) begin
      if (doneA === 1'b1) dones++;
      tick();
      n_vec++; if (busyA !== 1'b0) begin n_err++; $display("FAIL restart_idle cyc=%0d got busy=%b exp=0", n, busyA); end
    end
    n_vec++; if (dones != 1) begin n_err++; $display("FAIL restart_done_count got=%0d exp=1", dones); end
  endtask

  task automatic test_glitch();
    inA = 4'b0101;
    startA = 1; tick(); startA = 0;
    for (int n = 0; n < 12; n++) begin
      if (n == 3 || n == 4) begin
        inA[1] = 1'b1; #2; inA[1] = 1'b0;
      end
      if (n == 5) inA[1] = 1'b1;
      tick();
    end
    n_vec++; if (doneA !== 1'b1 || sampA !== 4'b0111) begin
      n_err++; $display("FAIL glitch_sample got done=%b sample=%b exp done=1 sample=0111", doneA, sampA);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    inA = 4'b1111;
    startA = 1; tick(); startA = 0;
    for (int n = 0; n < 7; n++) tick();
    n_vec++; if ({sA0, sA1} !== 2'b10 || busyA !== 1'b1) begin
      n_err++; $display("FAIL rstmid_on_ch2 got sel=%b busy=%b exp sel=10 busy=1", {sA0, sA1}, busyA);
    end
    rstA = 0; tick(); rstA = 1;
    n_vec++; if ({sA0, sA1} !== 2'b00 || busyA !== 1'b0 || doneA !== 1'b0) begin
      n_err++; $display("FAIL rstmid_idle got sel=%b busy=%b done=%b exp 00 0 0", {sA0, sA1}, busyA, doneA);
    end
    n_vec++; if (sampA !== 4'b0000) begin n_err++; $display("FAIL rstmid_sample got=%b exp=0000", sampA); end
    for (int n = 0; n < 14; n++) begin
      tick();
      n_vec++; if (doneA !== 1'b0 || busyA !== 1'b0) begin
        n_err++; $display("FAIL rstmid_quiet cyc=%0d got done=%b busy=%b exp 0 0", n, doneA, busyA);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic ed, eb;
    inC = 4'b1010;
    startC = 1; tick();
    for (int n = 0; n < 27; n++) begin
`ifdef MUX_SCAN_CONT_EN
      ed = ((n % 9) == 8);
      eb = !ed;
`else
      ed = ((n % 10) == 8);
      eb = ((n % 10) < 8);
`endif
      n_vec++; if (doneC !== ed || busyC !== eb) begin
        n_err++; $display("FAIL b2b cyc=%0d got done=%b busy=%b exp done=%b busy=%b", n, doneC, busyC, ed, eb);
      end
      if (ed) begin
        n_vec++; if (sampC !== 4'b1010) begin n_err++; $display("FAIL b2b_sample cyc=%0d got=%b exp=1010", n, sampC); end
      end
      tick();
    end
    startC = 0;
  endtask

  initial begin
    test_reset();
    test_scan_d3();
    test_scan_d1();
    test_restart();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
